// File: rtl/lfsr_pkg.sv
// Shared constants for the parametrised Galois LFSR: maximal-length tap masks
// (bit i set = x^i term, constant term implied) and the legal width range.
package lfsr_pkg;

    localparam int LFSR_MIN_WIDTH = 2;
    localparam int LFSR_MAX_WIDTH = 32;

    localparam logic [3:0]  LFSR_TAPS_4  = 4'b0010;
    localparam logic [4:0]  LFSR_TAPS_5  = 5'b00100;
    localparam logic [5:0]  LFSR_TAPS_6  = 6'b000010;
    localparam logic [6:0]  LFSR_TAPS_7  = 7'b0000010;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'b00011100;
    localparam logic [8:0]  LFSR_TAPS_9  = 9'h010;
    localparam logic [9:0]  LFSR_TAPS_10 = 10'h008;
    localparam logic [10:0] LFSR_TAPS_11 = 11'h004;
    localparam logic [11:0] LFSR_TAPS_12 = 12'h052;
    localparam logic [12:0] LFSR_TAPS_13 = 13'h001A;
    localparam logic [13:0] LFSR_TAPS_14 = 14'h0442;
    localparam logic [14:0] LFSR_TAPS_15 = 15'h0002;
    localparam logic [15:0] LFSR_TAPS_16 = 16'h100A;
    localparam logic [16:0] LFSR_TAPS_17 = 17'h00008;
    localparam logic [17:0] LFSR_TAPS_18 = 18'h00080;
    localparam logic [18:0] LFSR_TAPS_19 = 19'h00026;
    localparam logic [19:0] LFSR_TAPS_20 = 20'h00008;
    localparam logic [20:0] LFSR_TAPS_21 = 21'h000004;
    localparam logic [21:0] LFSR_TAPS_22 = 22'h000002;
    localparam logic [22:0] LFSR_TAPS_23 = 23'h000020;
    localparam logic [23:0] LFSR_TAPS_24 = 24'h000086;
    localparam logic [24:0] LFSR_TAPS_25 = 25'h0000008;
    localparam logic [25:0] LFSR_TAPS_26 = 26'h0000046;
    localparam logic [26:0] LFSR_TAPS_27 = 27'h0000026;
    localparam logic [27:0] LFSR_TAPS_28 = 28'h0000008;
    localparam logic [28:0] LFSR_TAPS_29 = 29'h00000004;
    localparam logic [29:0] LFSR_TAPS_30 = 30'h00000052;
    localparam logic [30:0] LFSR_TAPS_31 = 31'h00000008;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h00400006;

    // Per-edge action after reset has been resolved.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_STEP = 2'd1,
        OP_LOAD = 2'd2
    } lfsr_op_e;

    function automatic bit lfsr_width_ok(input int w);
        return (w >= LFSR_MIN_WIDTH) && (w <= LFSR_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single shift of a Galois LFSR: the MSB wraps into bit 0 and
// is XORed into every tapped position on the way up.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_4)
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);

    logic w_fb;

    assign w_fb      = i_state[WIDTH-1];
    assign o_next[0] = w_fb;

    for (genvar i = 1; i < WIDTH; i++) begin : g_bit
        assign o_next[i] = i_state[i-1] ^ (TAPS[i] & w_fb);
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR advancing STEPS shifts per enabled clock, with load,
// wrap detection and, when LFSR_LOCKUP_GUARD_EN is defined, all-zero protection.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_4),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             lockup
);

    if (!lfsr_width_ok(WIDTH)) begin : g_err_width
        $error("lfsr_gen: WIDTH=%0d outside %0d..%0d", WIDTH, LFSR_MIN_WIDTH, LFSR_MAX_WIDTH);
    end
    if (SEED == '0) begin : g_err_seed
        $error("lfsr_gen: SEED must be nonzero");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_err_steps
        $error("lfsr_gen: STEPS=%0d outside 1..%0d", STEPS, WIDTH);
    end

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_chain [STEPS+1];
    logic [WIDTH-1:0] w_stepped;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    lfsr_op_e         w_op;
`ifdef LFSR_LOCKUP_GUARD_EN
    logic             w_lock_set;
    logic             r_lockup;
`endif

    // STEPS shifts chained combinationally so a multi-step advance costs no latency.
    assign w_chain[0] = r_q;
    for (genvar k = 0; k < STEPS; k++) begin : g_chain
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .i_state (w_chain[k]),
            .o_next  (w_chain[k+1])
        );
    end
    assign w_stepped = w_chain[STEPS];

    always_comb begin
        if (load)
            w_op = OP_LOAD;
        else if (en)
            w_op = OP_STEP;
        else
            w_op = OP_HOLD;
    end

    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        w_lock_set  = 1'b0;
`endif
        case (w_op)
            OP_LOAD: begin
                w_q_next = load_value;
`ifdef LFSR_LOCKUP_GUARD_EN
                if (load_value == '0) begin
                    w_q_next   = SEED;
                    w_lock_set = 1'b1;
                end
`endif
            end
            OP_STEP: begin
                w_q_next    = w_stepped;
                w_wrap_next = (w_stepped == SEED);
`ifdef LFSR_LOCKUP_GUARD_EN
                // Zero is a fixed point of the shift; recover to SEED instead of sticking.
                if (r_q == '0) begin
                    w_q_next    = SEED;
                    w_wrap_next = 1'b0;
                    w_lock_set  = 1'b1;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= SEED;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_lockup <= 1'b0;
        else if (w_lock_set)
            r_lockup <= 1'b1;
    end

    assign lockup = r_lockup;
`else
    assign lockup = 1'b0;
`endif

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: three instances (default, STEPS=2, WIDTH=8)
// compared against a polynomial-arithmetic reference model.
`timescale 1ns/1ps
module tb_lfsr_gen;

`ifdef LFSR_LOCKUP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv4 = '0;
    logic [7:0] lv8 = '0;
    logic [3:0] qa, qb;
    logic [7:0] qc;
    logic       wa, wb, wc, la, lb, lc;

    int checks = 0;
    int failures = 0;

    logic [31:0] ma = '0, mb = '0, mc = '0;
    bit          ea, eb, ec, ka, kb, kc;

    always #5 clk = ~clk;

    lfsr_gen u_a (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_value(lv4),
        .q(qa), .wrap(wa), .lockup(la)
    );

    lfsr_gen #(.STEPS(2)) u_b (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_value(lv4),
        .q(qb), .wrap(wb), .lockup(lb)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(lfsr_pkg::LFSR_TAPS_8), .SEED(8'h01)) u_c (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_value(lv8),
        .q(qc), .wrap(wc), .lockup(lc)
    );

    // Multiply by x modulo P(x) = x^w + taps + 1.
    function automatic logic [31:0] mulx(input int w, input logic [31:0] taps, input logic [31:0] s);
        logic [63:0] t;
        t = {32'b0, s} << 1;
        if (t[w])
            t = t ^ ((64'd1 << w) | {32'b0, taps} | 64'd1);
        return t[31:0];
    endfunction

    task automatic mdl(input int w, input logic [31:0] taps, input int steps, input logic [31:0] seed,
                       input bit r, input bit ld, input bit e, input logic [31:0] lv,
                       inout logic [31:0] s, inout bit wr, inout bit lk);
        if (r) begin
            s = seed; wr = 1'b0; lk = 1'b0;
        end else if (ld) begin
            wr = 1'b0;
            if (lv == 0 && GUARD) begin
                s = seed; lk = 1'b1;
            end else begin
                s = lv;
            end
        end else if (e) begin
            if (s == 0 && GUARD) begin
                s = seed; lk = 1'b1; wr = 1'b0;
            end else begin
                for (int i = 0; i < steps; i++) s = mulx(w, taps, s);
                wr = (s == seed);
            end
        end else begin
            wr = 1'b0;
        end
    endtask

    // Drive one clock of stimulus and advance the model; returns 1ns after the edge.
    task automatic cycle(input bit r, input bit ld, input bit e, input logic [3:0] v4, input logic [7:0] v8);
        reset = r; load = ld; en = e; lv4 = v4; lv8 = v8;
        @(posedge clk);
        mdl(4, 32'h2, 1, 32'h1, r, ld, e, {28'b0, v4}, ma, ea, ka);
        mdl(4, 32'h2, 2, 32'h1, r, ld, e, {28'b0, v4}, mb, eb, kb);
        mdl(8, 32'h1C, 1, 32'h1, r, ld, e, {24'b0, v8}, mc, ec, kc);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 4'h0, 8'h00);
        cycle(1, 1, 1, 4'h9, 8'h99);
        checks++;
        if (qa !== 4'h1 || wa !== 1'b0 || la !== 1'b0) begin
            failures++;
            $display("FAIL reset_a q=%h wrap=%b lockup=%b required q=1 wrap=0 lockup=0", qa, wa, la);
        end
        checks++;
        if (qb !== 4'h1 || wb !== 1'b0 || lb !== 1'b0) begin
            failures++;
            $display("FAIL reset_b q=%h wrap=%b lockup=%b required q=1 wrap=0 lockup=0", qb, wb, lb);
        end
        checks++;
        if (qc !== 8'h01 || wc !== 1'b0 || lc !== 1'b0) begin
            failures++;
            $display("FAIL reset_c q=%h wrap=%b lockup=%b required q=01 wrap=0 lockup=0", qc, wc, lc);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] seq_a [7] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB};
        logic [3:0] seq_b [3] = '{4'h4, 4'h3, 4'hC};
        int wraps_a = 0, wraps_b = 0, first_a = 0;
        cycle(1, 0, 0, 4'h0, 8'h00);
        for (int i = 1; i <= 30; i++) begin
            cycle(0, 0, 1, 4'h0, 8'h00);
            if (wa === 1'b1) begin
                wraps_a++;
                if (first_a == 0) first_a = i;
            end
            if (wb === 1'b1) wraps_b++;
            if (i <= 7) begin
                checks++;
                if (qa !== seq_a[i-1]) begin
                    failures++;
                    $display("FAIL seq_a step %0d q=%h required %h", i, qa, seq_a[i-1]);
                end
            end
            if (i <= 3) begin
                checks++;
                if (qb !== seq_b[i-1]) begin
                    failures++;
                    $display("FAIL seq_steps2 step %0d q=%h required %h", i, qb, seq_b[i-1]);
                end
            end
            checks++;
            if (qa !== ma[3:0] || wa !== ea || qb !== mb[3:0] || wb !== eb) begin
                failures++;
                $display("FAIL seq_model step %0d a=%h/%b b=%h/%b required a=%h/%b b=%h/%b",
                         i, qa, wa, qb, wb, ma[3:0], ea, mb[3:0], eb);
            end
        end
        checks++;
        if (wraps_a != 2 || first_a != 15) begin
            failures++;
            $display("FAIL wrap_period_a wraps=%0d first=%0d required wraps=2 first=15", wraps_a, first_a);
        end
        checks++;
        if (wraps_b != 2) begin
            failures++;
            $display("FAIL wrap_period_steps2 wraps=%0d required 2", wraps_b);
        end
    endtask

    task automatic test_load();
        cycle(1, 0, 0, 4'h0, 8'h00);
        cycle(0, 1, 1, 4'hA, 8'hA5);
        checks++;
        if (qa !== 4'hA || wa !== 1'b0 || qb !== 4'hA || qc !== 8'hA5) begin
            failures++;
            $display("FAIL load_over_en a=%h wrap=%b b=%h c=%h required a=a wrap=0 b=a c=a5", qa, wa, qb, qc);
        end
        cycle(0, 0, 1, 4'h0, 8'h00);
        checks++;
        if (qa !== 4'h7 || qb !== 4'hE || qc !== mc[7:0]) begin
            failures++;
            $display("FAIL step_after_load a=%h b=%h c=%h required a=7 b=e c=%h", qa, qb, qc, mc[7:0]);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 4'h3, 8'h33);
            checks++;
            if (qa !== 4'h7 || wa !== 1'b0 || qb !== 4'hE) begin
                failures++;
                $display("FAIL hold cycle %0d a=%h wrap=%b b=%h required a=7 wrap=0 b=e", i, qa, wa, qb);
            end
        end
        cycle(0, 1, 0, 4'h1, 8'h01);
        checks++;
        if (qa !== 4'h1 || wa !== 1'b0 || wc !== 1'b0) begin
            failures++;
            $display("FAIL load_seed_no_wrap q=%h wrap=%b wrap_c=%b required q=1 wrap=0", qa, wa, wc);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 4'h0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 4'h0, 8'h00);
        checks++;
        if (qa !== 4'hC) begin
            failures++;
            $display("FAIL run_to_c q=%h required c", qa);
        end
        cycle(1, 1, 1, 4'h5, 8'h55);
        checks++;
        if (qa !== 4'h1 || wa !== 1'b0 || la !== 1'b0 || qb !== 4'h1 || qc !== 8'h01) begin
            failures++;
            $display("FAIL reset_mid a=%h wrap=%b lockup=%b b=%h c=%h required 1/0/0/1/01", qa, wa, la, qb, qc);
        end
    endtask

    task automatic test_zero_load();
        int bad = 0;
        cycle(1, 0, 0, 4'h0, 8'h00);
        cycle(0, 1, 1, 4'h0, 8'h00);
        checks++;
        if (qa !== (GUARD ? 4'h1 : 4'h0) || la !== GUARD || qc !== (GUARD ? 8'h01 : 8'h00) || lc !== GUARD) begin
            failures++;
            $display("FAIL zero_load a=%h lockup=%b c=%h lockup_c=%b required a=%h lockup=%b",
                     qa, la, qc, lc, GUARD ? 4'h1 : 4'h0, GUARD);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 1, 4'h0, 8'h00);
            checks++;
            if (la !== GUARD || lb !== GUARD || lc !== GUARD || qa !== ma[3:0] || wa !== ea
                || (!GUARD && (qa !== 4'h0 || wa !== 1'b0 || wb !== 1'b0))) begin
                failures++; bad++;
                $display("FAIL zero_run step %0d a=%h wrap=%b lockup=%b required a=%h wrap=%b lockup=%b",
                         i, qa, wa, la, ma[3:0], ea, GUARD);
            end
        end
        cycle(1, 0, 0, 4'h0, 8'h00);
        checks++;
        if (la !== 1'b0 || lc !== 1'b0 || qa !== 4'h1) begin
            failures++;
            $display("FAIL lockup_clear lockup=%b lockup_c=%b q=%h required 0/0/1", la, lc, qa);
        end
    endtask

    task automatic test_width8();
        bit seen [256];
        int distinct = 0, wraps = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        cycle(1, 0, 0, 4'h0, 8'h00);
        for (int i = 0; i < 255; i++) begin
            cycle(0, 0, 1, 4'h0, 8'h00);
            if (wc === 1'b1) wraps++;
            if (qc !== 8'h00 && !$isunknown(qc) && !seen[qc]) begin
                seen[qc] = 1'b1;
                distinct++;
            end
            checks++;
            if (qc !== mc[7:0] || wc !== ec) begin
                failures++;
                $display("FAIL w8_model step %0d q=%h wrap=%b required q=%h wrap=%b", i, qc, wc, mc[7:0], ec);
            end
        end
        checks++;
        if (wraps != 1 || distinct != 255 || qc !== 8'h01) begin
            failures++;
            $display("FAIL w8_period wraps=%0d distinct=%0d final=%h required 1/255/01", wraps, distinct, qc);
        end
    endtask

    task automatic test_random();
        bit r, ld, e;
        logic [3:0] v4;
        logic [7:0] v8;
        cycle(1, 0, 0, 4'h0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            ld = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            v4 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            v8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cycle(r, ld, e, v4, v8);
            checks++;
            if (qa !== ma[3:0] || wa !== ea || la !== ka || qb !== mb[3:0] || wb !== eb || lb !== kb
                || qc !== mc[7:0] || wc !== ec || lc !== kc) begin
                failures++;
                $display("FAIL random cyc %0d a=%h/%b/%b b=%h/%b/%b c=%h/%b/%b required a=%h/%b/%b b=%h/%b/%b c=%h/%b/%b",
                         i, qa, wa, la, qb, wb, lb, qc, wc, lc,
                         ma[3:0], ea, ka, mb[3:0], eb, kb, mc[7:0], ec, kc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_load();
        test_reset_mid();
        test_zero_load();
        test_width8();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
